// File: rtl/adc_pkg.sv
// Shared ADC constants and the sample record carried from capture to the effects datapath.
package adc_pkg;
   localparam int FRAME_LEN  = 16;
   localparam int LEAD_ZEROS = 4;
   localparam int DATA_W     = 12;
   localparam int CH_W       = 3;

   typedef struct packed {
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
   } adc_sample_t;
endpackage

// File: rtl/adc_sample_capture_if.sv
// Ready/valid sample stream from the capture stage to its consumer.
interface adc_sample_capture_if;
   import adc_pkg::*;

   logic              sample_valid;
   logic [DATA_W-1:0] sample_data;
   logic [CH_W-1:0]   sample_ch;
   logic              out_ready;

   modport master (output sample_valid, output sample_data, output sample_ch, input out_ready);
   modport slave  (input sample_valid, input sample_data, input sample_ch, output out_ready);
endinterface

// File: rtl/sample_fifo.sv
// Small FIFO with a registered head; a push into a full buffer is dropped unless a pop frees a slot.
module sample_fifo #(
   parameter int  DEPTH  = 2,
   parameter type elem_t = logic [7:0]
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  push,
   input  elem_t push_data,
   input  logic  pop,
   output logic  head_valid,
   output elem_t head_data,
   output logic  drop
);
   localparam int AW = $clog2(DEPTH);

   elem_t         mem [DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic          full, do_push, do_pop, empty_nxt;
   elem_t         head_nxt;

   always_comb begin
      full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      do_pop    = pop && head_valid;
      do_push   = push && (!full || do_pop);
      drop      = push && full && !do_pop;
      wr_nxt    = wr_ptr + (AW+1)'(do_push);
      rd_nxt    = rd_ptr + (AW+1)'(do_pop);
      empty_nxt = (wr_nxt == rd_nxt);
      // the incoming word becomes head when it lands in the slot the read pointer moves to
      head_nxt  = (do_push && (wr_ptr[AW-1:0] == rd_nxt[AW-1:0])) ? push_data : mem[rd_nxt[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         wr_ptr     <= wr_nxt;
         rd_ptr     <= rd_nxt;
         head_valid <= !empty_nxt;
         head_data  <= empty_nxt ? '0 : head_nxt;
      end
   end
endmodule

// File: rtl/adc_sample_capture.sv
// Deserialises ADC SPI frames into channel-tagged samples and buffers them for the effects datapath.
module adc_sample_capture
   import adc_pkg::adc_sample_t;
   import adc_pkg::CH_W;
#(
   parameter int DEPTH      = 2,
   parameter int FRAME_LEN  = adc_pkg::FRAME_LEN,
   parameter int LEAD_ZEROS = adc_pkg::LEAD_ZEROS,
   parameter int DATA_W     = adc_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs_b,
   input  logic              dout,
   input  logic [CH_W-1:0]   add,
   input  logic              err_clear,
   output logic              frame_err,
   output logic              overrun,
   adc_sample_capture_if.master smp
);
   localparam int                IDX_W = $clog2(FRAME_LEN);
   localparam logic [IDX_W-1:0]  LAST  = IDX_W'(FRAME_LEN - 1);
   localparam logic [IDX_W-1:0]  LZ    = IDX_W'(LEAD_ZEROS);

   logic [IDX_W-1:0]  bit_idx;
   logic [DATA_W-2:0] shift_reg;
   logic [CH_W-1:0]   ch_cur, ch_prev;
   logic              prev_ok;
   logic              push_q;
   adc_sample_t       push_word_q;
   adc_sample_t       head;
   logic              frame_done, abort, lead_err, fifo_drop;

   always_comb begin
      frame_done = !cs_b && (bit_idx == LAST);
      abort      = cs_b && (bit_idx != '0);
      lead_err   = !cs_b && (bit_idx < LZ) && dout;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx     <= '0;
         shift_reg   <= '0;
         ch_cur      <= '0;
         ch_prev     <= '0;
         prev_ok     <= 1'b0;
         push_q      <= 1'b0;
         push_word_q <= '0;
         frame_err   <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         if (cs_b)                 bit_idx <= '0;
         else if (bit_idx == LAST) bit_idx <= '0;
         else                      bit_idx <= bit_idx + 1'b1;

         if (!cs_b && (bit_idx == '0)) ch_cur <= add;
         if (!cs_b && (bit_idx >= LZ) && (bit_idx != LAST))
            shift_reg <= {shift_reg[DATA_W-3:0], dout};

         // the ADC answers for the channel addressed one frame earlier
         push_q           <= frame_done && prev_ok;
         push_word_q.ch   <= ch_prev;
         push_word_q.data <= {shift_reg, dout};

         if (frame_done) begin
            ch_prev <= ch_cur;
            prev_ok <= 1'b1;
         end
         if (abort) prev_ok <= 1'b0;

         if (abort || lead_err) frame_err <= 1'b1;
         else if (err_clear)    frame_err <= 1'b0;

         if (fifo_drop)      overrun <= 1'b1;
         else if (err_clear) overrun <= 1'b0;
      end
   end

   sample_fifo #(
      .DEPTH  (DEPTH),
      .elem_t (adc_sample_t)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push_q),
      .push_data  (push_word_q),
      .pop        (smp.out_ready),
      .head_valid (smp.sample_valid),
      .head_data  (head),
      .drop       (fifo_drop)
   );

   assign smp.sample_data = head.data;
   assign smp.sample_ch   = head.ch;
endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: framing, channel tagging, buffering, errors and reset.
module tb_adc_sample_capture;
   logic       clk = 1'b0;
   logic       reset;
   logic       cs_b;
   logic       dout;
   logic [2:0] add;
   logic       err_clear;
   logic       frame_err;
   logic       overrun;
   int         n_chk = 0;
   int         n_err = 0;

   adc_sample_capture_if smp ();

   adc_sample_capture #(.DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .cs_b      (cs_b),
      .dout      (dout),
      .add       (add),
      .err_clear (err_clear),
      .frame_err (frame_err),
      .overrun   (overrun),
      .smp       (smp.master)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_head(input string tag, input logic [2:0] ech, input logic [11:0] edat);
      chk({tag, "_valid"}, 32'(smp.sample_valid), 32'd1);
      chk({tag, "_ch"},    32'(smp.sample_ch),    32'(ech));
      chk({tag, "_data"},  32'(smp.sample_data),  32'(edat));
   endtask

   // mode 1: previous frame's sample must appear after this frame's first edge; mode 2: must not
   task automatic send_frame(input logic [15:0] word, input logic [2:0] a, input int n,
                             input int mode, input string tag,
                             input logic [2:0] ech, input logic [11:0] edat);
      logic [15:0] w;
      w = word;
      cs_b = 1'b0;
      for (int i = 0; i < n; i++) begin
         dout = w[4'(15 - i)];
         add  = (i == 0) ? a : ~a;
         tick();
         if (i == 0 && mode == 1) chk_head(tag, ech, edat);
         if (i == 0 && mode == 2) chk({tag, "_none"}, 32'(smp.sample_valid), 32'd0);
      end
      dout = 1'b0;
   endtask

   initial begin
      reset = 1'b1; cs_b = 1'b1; dout = 1'b0; add = 3'd0; err_clear = 1'b0;
      smp.out_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_valid", 32'(smp.sample_valid), 32'd0);
      chk("rst_data",  32'(smp.sample_data),  32'd0);
      chk("rst_ch",    32'(smp.sample_ch),    32'd0);
      chk("rst_ferr",  32'(frame_err),        32'd0);
      chk("rst_ovr",   32'(overrun),          32'd0);

      // continuous conversion: first frame discarded, then tagged samples
      send_frame(16'h0123, 3'd3, 16, 0, "f1", 3'd0, 12'h000);
      send_frame(16'h0ABC, 3'd5, 16, 2, "f1_drop", 3'd0, 12'h000);
      chk("lat_pre", 32'(smp.sample_valid), 32'd0);
      send_frame(16'h0FFF, 3'd5, 16, 1, "f2", 3'd3, 12'hABC);
      cs_b = 1'b1;
      tick();
      chk_head("f3", 3'd5, 12'hFFF);
      tick();
      chk("f3_popped", 32'(smp.sample_valid), 32'd0);
      chk("f_ferr", 32'(frame_err), 32'd0);

      // consumer stall across three frames
      smp.out_ready = 1'b0;
      send_frame(16'h0111, 3'd1, 16, 0, "oa", 3'd0, 12'h000);
      send_frame(16'h0222, 3'd2, 16, 0, "ob", 3'd0, 12'h000);
      send_frame(16'h0333, 3'd3, 16, 0, "oc", 3'd0, 12'h000);
      cs_b = 1'b1;
      tick();
      chk("ovr_set", 32'(overrun), 32'd1);
      chk_head("ovr_h0", 3'd5, 12'h111);
      tick();
      chk_head("ovr_stable", 3'd5, 12'h111);
      smp.out_ready = 1'b1;
      tick();
      chk_head("ovr_h1", 3'd1, 12'h222);
      tick();
      chk("ovr_empty", 32'(smp.sample_valid), 32'd0);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("ovr_clr", 32'(overrun), 32'd0);

      // leading one at idx 1: flagged, sample still delivered
      send_frame(16'h4555, 3'd4, 16, 0, "le", 3'd0, 12'h000);
      cs_b = 1'b1;
      tick();
      chk_head("le", 3'd3, 12'h555);
      chk("le_ferr", 32'(frame_err), 32'd1);
      tick(); tick();
      chk("le_sticky", 32'(frame_err), 32'd1);
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("le_clr", 32'(frame_err), 32'd0);

      // abort at idx 9, with err_clear on the same edge (set wins)
      send_frame(16'h0666, 3'd6, 9, 0, "ab", 3'd0, 12'h000);
      cs_b = 1'b1;
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("ab_ferr", 32'(frame_err), 32'd1);
      send_frame(16'h0777, 3'd7, 16, 2, "ab_part", 3'd0, 12'h000);
      send_frame(16'h0888, 3'd0, 16, 2, "ab_next", 3'd0, 12'h000);
      cs_b = 1'b1;
      tick();
      chk_head("ab_after", 3'd7, 12'h888);
      tick();
      err_clear = 1'b1;
      tick();
      err_clear = 1'b0;
      chk("ab_clr", 32'(frame_err), 32'd0);

      // full buffer: pop and push on the same edge
      smp.out_ready = 1'b0;
      send_frame(16'h0AAA, 3'd1, 16, 0, "pp_f", 3'd0, 12'h000);
      send_frame(16'h0BBB, 3'd2, 16, 0, "pp_g", 3'd0, 12'h000);
      send_frame(16'h0CCC, 3'd3, 16, 0, "pp_h", 3'd0, 12'h000);
      chk_head("pp_full", 3'd0, 12'hAAA);
      cs_b = 1'b1;
      smp.out_ready = 1'b1;
      tick();
      chk("pp_ovr", 32'(overrun), 32'd0);
      chk_head("pp_h1", 3'd1, 12'hBBB);
      tick();
      chk_head("pp_h2", 3'd2, 12'hCCC);
      tick();
      chk("pp_empty", 32'(smp.sample_valid), 32'd0);

      // reset at idx 7 with one sample buffered
      smp.out_ready = 1'b0;
      send_frame(16'h0DDD, 3'd4, 16, 0, "rs_i", 3'd0, 12'h000);
      send_frame(16'h0EEE, 3'd5, 7, 1, "rs_buf", 3'd3, 12'hDDD);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rs_valid", 32'(smp.sample_valid), 32'd0);
      chk("rs_ferr",  32'(frame_err), 32'd0);
      smp.out_ready = 1'b1;
      send_frame(16'h0123, 3'd6, 16, 0, "rs_k", 3'd0, 12'h000);
      send_frame(16'h0456, 3'd7, 16, 2, "rs_kdrop", 3'd0, 12'h000);
      cs_b = 1'b1;
      tick();
      chk_head("rs_l", 3'd6, 12'h456);
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
